// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared types, response codes and FSM states for the AXI4-Lite register bank
package axi_lite_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef logic [ADDR_W_DEF-1:0]   addr_t;
  typedef logic [DATA_W_DEF-1:0]   data_t;
  typedef logic [DATA_W_DEF/8-1:0] strb_t;
  typedef logic [1:0]              resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_COLLECT = 2'd1,
    WR_COMMIT  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// rtl/axi_lite_addr_decode.sv - combinational address to register index / range / read-only decode
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int                  ADDR_W   = 32,
  parameter int                  DATA_W   = 32,
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic [ADDR_W-1:0]           i_addr,
  output logic [$clog2(NUM_REGS)-1:0] o_idx,
  output logic                        o_oor,
  output logic                        o_ro
);

  localparam int                BYTE_LSB = $clog2(DATA_W / 8);
  localparam int                IDX_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(NUM_REGS * (DATA_W / 8));

  // Low byte-offset bits are dropped, so misaligned addresses land on their containing word
  assign o_idx = i_addr[BYTE_LSB +: IDX_W];
  assign o_oor = ({1'b0, i_addr} >= LIMIT);
  assign o_ro  = RO_MASK[o_idx] && !o_oor;

endmodule

// File: rtl/axi_lite_reg_bank.sv
// rtl/axi_lite_reg_bank.sv - AXI4-Lite slave register bank with strobes, read-only status slots and error responses
module axi_lite_reg_bank
  import axi_lite_pkg::*;
#(
  parameter int                           ADDR_W    = 32,
  parameter int                           DATA_W    = 32,
  parameter int                           NUM_REGS  = 16,
  parameter logic [NUM_REGS-1:0]          RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]   RESET_VAL = '0
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_W-1:0]            rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  input  logic [NUM_REGS*DATA_W-1:0]   status_i,
  output logic [NUM_REGS-1:0]          wr_pulse_o
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_W / 8;

  wr_state_e             r_wr_state;
  rd_state_e             r_rd_state;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_W-1:0]     r_awaddr;
  logic [DATA_W-1:0]     r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  r_bvalid;
  resp_t                 r_bresp;
  logic                  r_rvalid;
  resp_t                 r_rresp;
  logic [DATA_W-1:0]     r_rdata;
  logic [NUM_REGS-1:0]   r_wr_pulse;
  logic [DATA_W-1:0]     r_regs [NUM_REGS];

  logic [IDX_W-1:0]      w_aw_idx;
  logic [IDX_W-1:0]      w_ar_idx;
  logic                  w_aw_oor;
  logic                  w_aw_ro;
  logic                  w_ar_oor;
  logic                  w_ar_ro;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_aw_have;
  logic                  w_w_have;

  axi_lite_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_aw_dec (
    .i_addr(r_awaddr), .o_idx(w_aw_idx), .o_oor(w_aw_oor), .o_ro(w_aw_ro)
  );

  axi_lite_addr_decode #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_ar_dec (
    .i_addr(araddr), .o_idx(w_ar_idx), .o_oor(w_ar_oor), .o_ro(w_ar_ro)
  );

  assign awready   = !areset && !r_aw_held && !r_bvalid;
  assign wready    = !areset && !r_w_held && !r_bvalid;
  assign arready   = !areset && (r_rd_state == RD_IDLE);
  assign w_aw_hs   = awvalid && awready;
  assign w_w_hs    = wvalid && wready;
  assign w_ar_hs   = arvalid && arready;
  assign w_aw_have = r_aw_held || w_aw_hs;
  assign w_w_have  = r_w_held || w_w_hs;

  assign bvalid     = r_bvalid;
  assign bresp      = r_bresp;
  assign rvalid     = r_rvalid;
  assign rresp      = r_rresp;
  assign rdata      = r_rdata;
  assign wr_pulse_o = r_wr_pulse;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
    assign regs_o[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : r_regs[g];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_state <= WR_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= RO_MASK[i] ? '0 : RESET_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      r_wr_pulse <= '0;
      case (r_wr_state)
        WR_IDLE, WR_COLLECT: begin
          if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= awaddr;
          end
          if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
          end
          if (w_aw_have && w_w_have)      r_wr_state <= WR_COMMIT;
          else if (w_aw_have || w_w_have) r_wr_state <= WR_COLLECT;
          else                            r_wr_state <= WR_IDLE;
        end
        WR_COMMIT: begin
          r_aw_held  <= 1'b0;
          r_w_held   <= 1'b0;
          r_bvalid   <= 1'b1;
          r_wr_state <= WR_RESP;
          if (w_aw_oor) begin
            r_bresp <= RESP_DECERR;
          end else if (w_aw_ro) begin
            r_bresp <= RESP_SLVERR;
          end else begin
            // Pulse fires on any accepted writable commit, even with an all-zero strobe
            r_bresp              <= RESP_OKAY;
            r_wr_pulse[w_aw_idx] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (r_wstrb[b]) r_regs[w_aw_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
            end
          end
        end
        WR_RESP: begin
          if (bready) begin
            r_bvalid   <= 1'b0;
            r_wr_state <= WR_IDLE;
          end
        end
        default: r_wr_state <= WR_IDLE;
      endcase
    end
  end

  // Register array is read before any same-edge commit lands, giving pre-commit data
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rd_state <= RD_IDLE;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rvalid   <= 1'b1;
            r_rd_state <= RD_RESP;
            if (w_ar_oor) begin
              r_rdata <= '0;
              r_rresp <= RESP_DECERR;
            end else if (w_ar_ro) begin
              r_rdata <= status_i[w_ar_idx*DATA_W +: DATA_W];
              r_rresp <= RESP_OKAY;
            end else begin
              r_rdata <= r_regs[w_ar_idx];
              r_rresp <= RESP_OKAY;
            end
          end
        end
        RD_RESP: begin
          if (rready) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb/tb_axi_lite_reg_bank.sv - directed self-checking bench for axi_lite_reg_bank
module tb_axi_lite_reg_bank;

  localparam logic [511:0] RV = {384'h0, 32'h0000_1234, 32'hFFFF_FFFF, 32'hA5A5_0000, 32'h0000_1111};
  localparam logic [511:0] ST = {384'h0, 32'hDEAD_BEEF, 32'h0, 32'h7777_7777, 32'h0};

  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [31:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [511:0] regs_o;
  logic [511:0] status_i;
  logic [15:0]  wr_pulse_o;

  int errors = 0;
  int checks = 0;

  axi_lite_reg_bank #(
    .ADDR_W(32), .DATA_W(32), .NUM_REGS(16), .RO_MASK(16'h0008), .RESET_VAL(RV)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .status_i(status_i), .wr_pulse_o(wr_pulse_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] slot(input int i);
    return regs_o[i*32 +: 32];
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] ed, input logic [1:0] er, input string tag);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b1;
    chk({tag, "_arready"}, 64'(arready), 64'd1);
    step();
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    chk({tag, "_rdata"}, 64'(rdata), 64'(ed));
    chk({tag, "_rresp"}, 64'(rresp), 64'(er));
    step();
    chk({tag, "_rvalid_drop"}, 64'(rvalid), 64'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] er, input logic [15:0] ep, input string tag);
    awaddr  = addr;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk({tag, "_bvalid_commit"}, 64'(bvalid), 64'd0);
    step();
    chk({tag, "_bvalid"}, 64'(bvalid), 64'd1);
    chk({tag, "_bresp"}, 64'(bresp), 64'(er));
    chk({tag, "_pulse"}, 64'(wr_pulse_o), 64'(ep));
    step();
    chk({tag, "_bvalid_drop"}, 64'(bvalid), 64'd0);
    chk({tag, "_pulse_drop"}, 64'(wr_pulse_o), 64'd0);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    status_i = ST;

    // Reset state
    step();
    step();
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_pulse", 64'(wr_pulse_o), 64'd0);
    chk("rst_reg1", 64'(slot(1)), 64'hA5A5_0000);
    chk("rst_reg3_ro", 64'(slot(3)), 64'd0);
    areset = 1'b0;
    #1;
    chk("rel_awready", 64'(awready), 64'd1);
    chk("rel_wready", 64'(wready), 64'd1);
    chk("rel_arready", 64'(arready), 64'd1);

    // 1: read reset value
    rd(32'h04, 32'hA5A5_0000, 2'b00, "t1_rd_reg1");

    // 2: AW two cycles before W, partial strobe
    awaddr = 32'h08; awvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0;
    chk("t2_awready_held", 64'(awready), 64'd0);
    step();
    wdata = 32'h1234_5678; wstrb = 4'b0101; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    chk("t2_reg2_before", 64'(slot(2)), 64'hFFFF_FFFF);
    step();
    chk("t2_reg2", 64'(slot(2)), 64'hFF34_FF78);
    chk("t2_pulse", 64'(wr_pulse_o), 64'h0004);
    chk("t2_bvalid", 64'(bvalid), 64'd1);
    chk("t2_bresp", 64'(bresp), 64'd0);
    step();
    chk("t2_pulse_drop", 64'(wr_pulse_o), 64'd0);
    chk("t2_bvalid_drop", 64'(bvalid), 64'd0);

    // 3: out of range
    wr(32'h40, 32'hCCCC_CCCC, 4'hF, 2'b11, 16'h0000, "t3_wr_oor");
    chk("t3_reg0", 64'(slot(0)), 64'h0000_1111);
    chk("t3_reg15", 64'(slot(15)), 64'd0);
    rd(32'h40, 32'h0, 2'b11, "t3_rd_oor");
    rd(32'h3C, 32'h0, 2'b00, "t3_rd_last");
    rd(32'h0A, 32'hFF34_FF78, 2'b00, "t3_rd_misaligned");

    // 4: read-only register
    rd(32'h0C, 32'hDEAD_BEEF, 2'b00, "t4_rd_ro");
    wr(32'h0C, 32'h1111_1111, 4'hF, 2'b10, 16'h0000, "t4_wr_ro");
    chk("t4_reg3", 64'(slot(3)), 64'd0);
    wr(32'h10, 32'hABCD_0000, 4'h0, 2'b00, 16'h0010, "t4_wr_nostrb");
    chk("t4_reg4", 64'(slot(4)), 64'd0);

    // 5: backpressure, with AR landing on the commit edge of the same register
    awaddr = 32'h14; wdata = 32'h0000_0055; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 32'h14; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    chk("t5_rdata_precommit", 64'(rdata), 64'd0);
    chk("t5_reg5_committed", 64'(slot(5)), 64'h55);
    for (int k = 0; k < 5; k++) begin
      chk("t5_bvalid_hold", 64'(bvalid), 64'd1);
      chk("t5_rvalid_hold", 64'(rvalid), 64'd1);
      chk("t5_bresp_hold", 64'(bresp), 64'd0);
      chk("t5_rdata_hold", 64'(rdata), 64'd0);
      chk("t5_readies_low", 64'({awready, wready, arready}), 64'd0);
      step();
    end
    bready = 1'b1; rready = 1'b1;
    step();
    chk("t5_bvalid_rel", 64'(bvalid), 64'd0);
    chk("t5_rvalid_rel", 64'(rvalid), 64'd0);
    rd(32'h14, 32'h0000_0055, 2'b00, "t5_rd_reg5");

    // 6: reset while a response is pending
    awaddr = 32'h00; wdata = 32'hCAFE_0000; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("t6_bvalid", 64'(bvalid), 64'd1);
    chk("t6_reg0_written", 64'(slot(0)), 64'hCAFE_0000);
    #2;
    areset = 1'b1;
    #1;
    chk("t6_bvalid_async", 64'(bvalid), 64'd0);
    chk("t6_reg0_reset", 64'(slot(0)), 64'h0000_1111);
    chk("t6_reg5_reset", 64'(slot(5)), 64'd0);
    chk("t6_awready_rst", 64'(awready), 64'd0);
    step();
    areset = 1'b0;
    #1;
    chk("t6_readies_rel", 64'({awready, wready, arready}), 64'h7);
    rd(32'h08, 32'hFFFF_FFFF, 2'b00, "t6_rd_reg2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
